// File: rtl/pc_redirect_unit_if.sv
// Purpose: groups the execute-side redirect inputs and fetch-side outputs of pc_redirect_unit.
// Latency: wiring only.
// Backpressure: stall travels with the bundle. PC_REDIRECT_STATS_EN adds the counter outputs.
interface pc_redirect_unit_if;
    logic        stall;
    logic        ex_valid;
    logic        ex_br_tk;
    logic        ex_jump;
    logic [31:0] ex_target;
    logic [31:0] f_pc;
    logic        f_valid;
    logic        flush_d;
    logic        flush_e;
    logic        misalign;
`ifdef PC_REDIRECT_STATS_EN
    logic [31:0] stat_redirects;
    logic [31:0] stat_stall_cycles;
`endif

    // Execute/hazard side: drives the decision and sees the fetch PC and flushes.
    modport master (
        output stall, ex_valid, ex_br_tk, ex_jump, ex_target,
`ifdef PC_REDIRECT_STATS_EN
        input  stat_redirects, stat_stall_cycles,
`endif
        input  f_pc, f_valid, flush_d, flush_e, misalign
    );

    // PC unit side.
    modport slave (
        input  stall, ex_valid, ex_br_tk, ex_jump, ex_target,
`ifdef PC_REDIRECT_STATS_EN
        output stat_redirects, stat_stall_cycles,
`endif
        output f_pc, f_valid, flush_d, flush_e, misalign
    );
endinterface

// File: rtl/pc_redirect_unit.sv
// Purpose: fetch PC generator with execute-stage redirect, post-redirect bubble and misaligned-target halt.
// Latency: a redirect seen in cycle N puts the target on f_pc in cycle N+1, and the next sequential PC in N+2.
// Backpressure: stall holds the PC unless a redirect is taken, because a redirect overrides stall.
// Optional: define PC_REDIRECT_STATS_EN for the redirect and stall-cycle counters.
module pc_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0100_0000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic               clock,
    input  logic               reset,
    pc_redirect_unit_if.slave  bus
);
    typedef enum logic [1:0] {BOOT, RUN, BUBBLE, HALT} state_t;

    state_t      state;
    state_t      state_nxt;
    logic [31:0] pc_q;
    logic [31:0] pc_nxt;
    logic        mis_q;
    logic        mis_nxt;
    logic        redirect;
    logic        valid_raw;
    logic        flush_raw;

    // Redirects only count in RUN: in BUBBLE execute holds the slot we just flushed.
    assign redirect = bus.ex_valid & (bus.ex_br_tk | bus.ex_jump) & (state == RUN);

    // State, PC and sticky misalign registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BOOT;
            pc_q  <= RESET_PC;
            mis_q <= 1'b0;
        end else begin
            state <= state_nxt;
            pc_q  <= pc_nxt;
            mis_q <= mis_nxt;
        end
    end

    // Next-state, next-PC and the raw fetch-valid/flush decode.
    always_comb begin
        state_nxt = state;
        pc_nxt    = pc_q;
        mis_nxt   = mis_q;
        valid_raw = 1'b0;
        flush_raw = 1'b0;
        case (state)
            BOOT: begin
                state_nxt = RUN;
            end
            RUN: begin
                valid_raw = 1'b1;
                if (redirect) begin
                    // A younger instruction is killed either way, even if it is stalled.
                    flush_raw = 1'b1;
                    if (bus.ex_target[1:0] == 2'b00) begin
                        pc_nxt    = bus.ex_target;
                        state_nxt = BUBBLE;
                    end else begin
                        mis_nxt   = 1'b1;
                        state_nxt = HALT;
                    end
                end else if (!bus.stall) begin
                    pc_nxt = pc_q + 32'(PC_STEP);
                end
            end
            BUBBLE: begin
                valid_raw = 1'b1;
                state_nxt = RUN;
                if (!bus.stall) begin
                    pc_nxt = pc_q + 32'(PC_STEP);
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = BOOT;
            end
        endcase
    end

    // Reset overrides everything, so it also suppresses fetch and flushes in its own cycle.
    assign bus.f_pc     = pc_q;
    assign bus.f_valid  = valid_raw & ~reset;
    assign bus.flush_d  = flush_raw & ~reset;
    assign bus.flush_e  = flush_raw & ~reset;
    assign bus.misalign = mis_q;

`ifdef PC_REDIRECT_STATS_EN
    logic [31:0] redir_cnt;
    logic [31:0] stall_cnt;

    // Event counters, which wrap naturally at 2^32.
    always_ff @(posedge clock) begin
        if (reset) begin
            redir_cnt <= 32'd0;
            stall_cnt <= 32'd0;
        end else begin
            if (redirect) begin
                redir_cnt <= redir_cnt + 32'd1;
            end
            if ((state == RUN || state == BUBBLE) && bus.stall && !redirect) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    assign bus.stat_redirects    = redir_cnt;
    assign bus.stat_stall_cycles = stall_cnt;
`endif
endmodule

// File: tb/tb_pc_redirect_unit.sv
// Directed bench for pc_redirect_unit: per-cycle expected outputs go into a scoreboard queue.
// A negedge monitor pops and compares each entry against the DUT.
module tb_pc_redirect_unit;
    logic clock;
    logic reset;

    pc_redirect_unit_if bus();

    pc_redirect_unit dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string       name;
        logic        pc_chk;
        logic [31:0] pc;
        logic        vld;
        logic        fd;
        logic        fe;
        logic        mis;
        logic        stat_chk;
        logic [31:0] redirs;
        logic [31:0] stalls;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Monitor: compare the current cycle's outputs against the oldest expectation.
    always @(negedge clock) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_checks++;
            if (bus.f_valid !== e.vld || bus.flush_d !== e.fd || bus.flush_e !== e.fe ||
                (e.pc_chk && (bus.f_pc !== e.pc || bus.misalign !== e.mis))) begin
                n_fail++;
                $display("FAIL %s: got pc=%h vld=%b fd=%b fe=%b mis=%b, want pc=%h vld=%b fd=%b fe=%b mis=%b",
                         e.name, bus.f_pc, bus.f_valid, bus.flush_d, bus.flush_e, bus.misalign,
                         e.pc, e.vld, e.fd, e.fe, e.mis);
            end
`ifdef PC_REDIRECT_STATS_EN
            if (e.stat_chk) begin
                n_checks++;
                if (bus.stat_redirects !== e.redirs || bus.stat_stall_cycles !== e.stalls) begin
                    n_fail++;
                    $display("FAIL %s_stats: got redirects=%0d stalls=%0d, want redirects=%0d stalls=%0d",
                             e.name, bus.stat_redirects, bus.stat_stall_cycles, e.redirs, e.stalls);
                end
            end
`endif
        end
    end

    // Drives one cycle of inputs just after the rising edge and queues the expected outputs for that cycle.
    task automatic step(input string nm, input logic rst, input logic stl, input logic v,
                        input logic tk, input logic jp, input logic [31:0] tgt,
                        input logic pchk, input logic [31:0] epc, input logic evld,
                        input logic efl, input logic emis,
                        input logic schk = 1'b0, input logic [31:0] er = 32'd0,
                        input logic [31:0] es = 32'd0);
        exp_t e;
        @(posedge clock);
        #1;
        reset         = rst;
        bus.stall     = stl;
        bus.ex_valid  = v;
        bus.ex_br_tk  = tk;
        bus.ex_jump   = jp;
        bus.ex_target = tgt;
        e.name     = nm;
        e.pc_chk   = pchk;
        e.pc       = epc;
        e.vld      = evld;
        e.fd       = efl;
        e.fe       = efl;
        e.mis      = emis;
        e.stat_chk = schk;
        e.redirs   = er;
        e.stalls   = es;
        exp_q.push_back(e);
    endtask

    initial begin
        reset         = 1'b1;
        bus.stall     = 1'b0;
        bus.ex_valid  = 1'b0;
        bus.ex_br_tk  = 1'b0;
        bus.ex_jump   = 1'b0;
        bus.ex_target = 32'd0;

        //     name          rst stl v  tk jp target        pchk pc            vld fl mis
        step("reset_cycle",  1, 0, 0, 0, 0, 32'h0,         0, 32'h0,         0, 0, 0);
        step("boot",         0, 0, 0, 0, 0, 32'h0,         1, 32'h0100_0000, 0, 0, 0);
        step("run0",         0, 0, 0, 0, 0, 32'h0,         1, 32'h0100_0000, 1, 0, 0);
        step("run4",         0, 0, 0, 0, 0, 32'h0,         1, 32'h0100_0004, 1, 0, 0);
        step("run8",         0, 0, 0, 0, 0, 32'h0,         1, 32'h0100_0008, 1, 0, 0);
        step("runC",         0, 0, 0, 0, 0, 32'h0,         1, 32'h0100_000C, 1, 0, 0);
        step("br_taken",     0, 0, 1, 1, 0, 32'h0100_0200, 1, 32'h0100_0010, 1, 1, 0);
        step("bubble_ign",   0, 0, 1, 1, 0, 32'h0100_0400, 1, 32'h0100_0200, 1, 0, 0);
        step("jmp_vs_stall", 0, 1, 1, 0, 1, 32'h0100_0080, 1, 32'h0100_0204, 1, 1, 0);
        step("bubble_stall", 0, 1, 0, 0, 0, 32'h0,         1, 32'h0100_0080, 1, 0, 0);
        step("run_stall",    0, 1, 0, 0, 0, 32'h0,         1, 32'h0100_0080, 1, 0, 0);
        step("exv_low",      0, 0, 0, 1, 0, 32'h0100_0300, 1, 32'h0100_0080, 1, 0, 0);
        step("jmp_top",      0, 0, 1, 0, 1, 32'hFFFF_FFFC, 1, 32'h0100_0084, 1, 1, 0);
        step("at_top",       0, 0, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFC, 1, 0, 0);
        step("wrap_misal",   0, 0, 1, 1, 0, 32'h0100_0102, 1, 32'h0000_0000, 1, 1, 0);
        step("halt_ign",     0, 0, 1, 1, 0, 32'h0100_0200, 1, 32'h0000_0000, 0, 0, 1);
        step("halt_hold",    0, 0, 0, 0, 0, 32'h0,         1, 32'h0000_0000, 0, 0, 1);
        step("halt_reset",   1, 0, 1, 0, 1, 32'h0100_0200, 1, 32'h0000_0000, 0, 0, 1);
        step("boot2",        0, 0, 0, 0, 0, 32'h0,         1, 32'h0100_0000, 0, 0, 0);
        step("run2",         0, 0, 0, 0, 0, 32'h0,         1, 32'h0100_0000, 1, 0, 0);
        step("rst_vs_redir", 1, 0, 1, 1, 0, 32'h0100_0800, 1, 32'h0100_0004, 0, 0, 0);
        step("boot3",        0, 0, 0, 0, 0, 32'h0,         1, 32'h0100_0000, 0, 0, 0,
             1'b1, 32'd0, 32'd0);
        step("st_stall1",    0, 1, 0, 0, 0, 32'h0,         1, 32'h0100_0000, 1, 0, 0);
        step("st_stall2",    0, 1, 0, 0, 0, 32'h0,         1, 32'h0100_0000, 1, 0, 0);
        step("st_redir1",    0, 0, 1, 0, 1, 32'h0100_0040, 1, 32'h0100_0000, 1, 1, 0);
        step("st_bub_stall", 0, 1, 0, 0, 0, 32'h0,         1, 32'h0100_0040, 1, 0, 0);
        step("st_redir2",    0, 1, 1, 1, 0, 32'h0100_0100, 1, 32'h0100_0040, 1, 1, 0);
        step("st_bub_stal2", 0, 1, 0, 0, 0, 32'h0,         1, 32'h0100_0100, 1, 0, 0);
        step("st_stall5",    0, 1, 0, 0, 0, 32'h0,         1, 32'h0100_0100, 1, 0, 0);
        step("both_tk_jmp",  0, 0, 1, 1, 1, 32'h0100_0020, 1, 32'h0100_0100, 1, 1, 0);
        step("st_bubble",    0, 0, 0, 0, 0, 32'h0,         1, 32'h0100_0020, 1, 0, 0);
        step("st_final",     0, 0, 0, 0, 0, 32'h0,         1, 32'h0100_0024, 1, 0, 0,
             1'b1, 32'd3, 32'd5);

        // Let the monitor consume every queued expectation, within a bounded wait.
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) begin
            @(posedge clock);
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d entries left, want 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_redirect_unit.md
Name: pc_redirect_unit

Overview:
- Fetch-side PC generator and control-flow redirect controller for the five-stage core.
- Sits directly downstream of the execute-stage branch-taken logic. Consumes the taken/jump decision and the target address from execute.
- Drives the fetch PC and the flush strobes for the IF/ID and ID/EX pipeline registers.
- Handles hazard stalls, a post-redirect bubble, and misaligned-target halting.

Parameters:
- RESET_PC, 32'h0100_0000, PC presented after reset.
- PC_STEP, 4, sequential increment in bytes.

Ports:
- clock  input  1  core clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  hazard-unit stall; holds PC when no redirect.
- ex_valid  input  1  execute stage holds a real, unflushed instruction.
- ex_br_tk  input  1  conditional branch taken (from execute branch logic).
- ex_jump  input  1  unconditional jump (JAL/JALR) in execute.
- ex_target  input  32  redirect target computed in execute.
- f_pc  output  32  fetch address to instruction memory.
- f_valid  output  1  f_pc is a real fetch; IF/ID may capture.
- flush_d  output  1  kill IF/ID contents this edge.
- flush_e  output  1  kill ID/EX contents this edge.
- misalign  output  1  sticky: redirect target not word-aligned.

Behaviour:
- Internal signal redirect = ex_valid & (ex_br_tk | ex_jump) & (state == RUN).
- States:
  - BOOT: entered on reset.
  - RUN: normal fetch.
  - BUBBLE: one cycle after a redirect.
  - HALT: terminal until reset.
- Reset (reset=1 at an edge):
  - state <= BOOT, f_pc <= RESET_PC, misalign <= 0.
  - Outputs during the reset cycle and in BOOT: f_valid=0, flush_d=0, flush_e=0.
- BOOT -> RUN unconditionally after one cycle; f_pc is unchanged.
- RUN, f_valid=1:
  - redirect with ex_target[1:0]==0: flush_d=1 and flush_e=1 combinationally in the same cycle. At the edge: f_pc <= ex_target, state <= BUBBLE.
  - redirect with ex_target[1:0]!=0: flush_d=flush_e=1. At the edge: misalign <= 1, state <= HALT, f_pc unchanged.
  - No redirect, stall=1: f_pc holds; flushes 0.
  - No redirect, stall=0: f_pc <= f_pc + PC_STEP, modulo 2^32. 32'hFFFF_FFFC wraps to 32'h0000_0000.
- Redirect vs stall: if redirect and stall are both 1, redirect wins. The stalled instruction is younger and is flushed.
- BUBBLE:
  - f_valid=1, flush_d=flush_e=0, redirect is ignored (execute holds a flushed slot).
  - stall=0: f_pc <= f_pc + PC_STEP, state <= RUN.
  - stall=1: f_pc holds, state <= RUN.
- HALT: f_valid=0, flushes 0, f_pc frozen, misalign held at 1. Only reset exits.
- Latency:
  - Redirect decision in cycle N -> target on f_pc in cycle N+1.
  - First sequential fetch after the target in cycle N+2 (absent stall).
- Reset mid-operation: reset overrides every other input at the same edge, including a redirect.
- ex_br_tk and ex_jump both high is legal; treated as a single redirect.

Optional Feature:
- Macro: PC_REDIRECT_STATS_EN.
- Defined:
  - Adds outputs stat_redirects[31:0] and stat_stall_cycles[31:0].
  - stat_redirects increments on each aligned or misaligned redirect edge.
  - stat_stall_cycles increments on each RUN/BUBBLE edge with stall=1 and no redirect.
  - Both counters are cleared by reset and wrap at 2^32.
- Undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- Reset, then 4 cycles with stall=0 and no redirect -> f_valid=0 in BOOT; f_pc sequence 0x01000000, 0x01000000, 0x01000004, 0x01000008, 0x0100000C.
- In RUN at f_pc=0x01000010, ex_valid=1, ex_br_tk=1, ex_target=0x01000200 -> flush_d=flush_e=1 that cycle; next cycle f_pc=0x01000200 (BUBBLE); following cycle 0x01000204.
- Same-cycle stall=1 and ex_jump=1, ex_target=0x01000080 -> redirect wins; f_pc=0x01000080 next cycle.
- Redirect while in BUBBLE (ex_valid=1, ex_br_tk=1, target 0x01000400) -> ignored; no flush; f_pc advances by 4.
- ex_target=0x01000102 on a taken branch -> flushes asserted; then misalign=1, f_valid=0, f_pc frozen; reset clears to f_pc=0x01000000, misalign=0.
- f_pc=0xFFFFFFFC with stall=0 -> next f_pc=0x00000000. With PC_REDIRECT_STATS_EN defined, after 3 redirects and 5 stall cycles -> stat_redirects=3, stat_stall_cycles=5.
